// File: rtl/alu_control_fsm.sv
// -----------------------------------------------------------------------------
// alu_control_fsm
//
// Multicycle control unit for a small RV32I subset (R-type ALU, I-type ALU,
// LW, SW, BEQ/BNE). It fetches an instruction over a valid handshake, latches
// it into an internal instruction register, decodes it and then steps through
// EXECUTE / MEM / WB, producing the control strobes for the regfile, immgen,
// ALU, data memory and PC.
//
// All outputs are decoded from the state register and the instruction
// register. The only exceptions are ir_load, which follows instr_valid during
// FETCH, and the SW/branch pc_write strobes, which depend on mem_ready and
// alu_result[0] in the cycle they are taken. Because the decode is
// combinational on registered state, an asynchronous reset clears every
// output immediately.
//
// Ports
//   clk              in   1    clock, rising edge
//   rst_n            in   1    asynchronous active-low reset
//   instr            in   32   instruction word from instruction memory
//   instr_valid      in   1    instr valid; sampled only in FETCH
//   mem_ready        in   1    data memory finished the current access
//   alu_result       in   N    ALU output; bit 0 resolves branches
//   instr_req        out  1    request instruction at current PC
//   ir_load          out  1    datapath latches instr (1-cycle pulse)
//   rs1, rs2, rd     out  5    register indices of the latched instruction
//   imm_sel          out  2    0=I, 1=S, 2=B immediate format
//   alu_instruction  out  OPW  ALU operation code (ALU_* below)
//   alusrc           out  1    1 = immediate second operand
//   mem_read         out  1    data read, held until mem_ready
//   mem_write        out  1    data write, held until mem_ready
//   reg_write        out  1    regfile write enable (1-cycle pulse)
//   wb_src           out  1    0 = ALU result, 1 = load data
//   pc_write         out  1    PC update, one pulse per retired instruction
//   pc_src           out  1    0 = PC+4, 1 = PC+B-immediate
//   illegal          out  1    sticky: unsupported encoding decoded
// -----------------------------------------------------------------------------
module alu_control_fsm #(
   parameter int N   = 32,
   parameter int OPW = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [31:0]    instr,
   input  logic           instr_valid,
   input  logic           mem_ready,
   input  logic [N-1:0]   alu_result,
   output logic           instr_req,
   output logic           ir_load,
   output logic [4:0]     rs1,
   output logic [4:0]     rs2,
   output logic [4:0]     rd,
   output logic [1:0]     imm_sel,
   output logic [OPW-1:0] alu_instruction,
   output logic           alusrc,
   output logic           mem_read,
   output logic           mem_write,
   output logic           reg_write,
   output logic           wb_src,
   output logic           pc_write,
   output logic           pc_src,
   output logic           illegal
);

   // ALU operation codes shared with the ALU
   localparam logic [OPW-1:0] ALU_ADD  = OPW'(4'd0);
   localparam logic [OPW-1:0] ALU_SUB  = OPW'(4'd1);
   localparam logic [OPW-1:0] ALU_AND  = OPW'(4'd2);
   localparam logic [OPW-1:0] ALU_OR   = OPW'(4'd3);
   localparam logic [OPW-1:0] ALU_XOR  = OPW'(4'd4);
   localparam logic [OPW-1:0] ALU_SLT  = OPW'(4'd5);
   localparam logic [OPW-1:0] ALU_SLTU = OPW'(4'd6);
   localparam logic [OPW-1:0] ALU_SLL  = OPW'(4'd7);
   localparam logic [OPW-1:0] ALU_SRL  = OPW'(4'd8);
   localparam logic [OPW-1:0] ALU_SRA  = OPW'(4'd9);
   localparam logic [OPW-1:0] ALU_EQ   = OPW'(4'd10);

   // FSM state encoding
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_EXECUTE = 3'd3;
   localparam logic [2:0] S_MEM     = 3'd4;
   localparam logic [2:0] S_WB      = 3'd5;
   localparam logic [2:0] S_TRAP    = 3'd6;

   // Supported major opcodes
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   // Immediate format selects
   localparam logic [1:0] IMM_I = 2'd0;
   localparam logic [1:0] IMM_S = 2'd1;
   localparam logic [1:0] IMM_B = 2'd2;

   logic [2:0]     state_q;
   logic [2:0]     state_d;
   logic [31:0]    ir_q;
   logic [31:0]    ir_d;

   logic [6:0]     opcode_s;
   logic [2:0]     funct3_s;
   logic [6:0]     funct7_s;
   logic           is_r_s;
   logic           is_i_s;
   logic           is_lw_s;
   logic           is_sw_s;
   logic           is_br_s;
   logic           legal_s;
   logic [OPW-1:0] alu_op_s;
   logic           alusrc_s;
   logic [1:0]     imm_sel_s;
   logic           unused_s;

   // ALU code for register/immediate arithmetic. funct7[5] selects SUB only
   // for R-type (for I-type that bit is part of the immediate), but selects
   // SRA for both R and I shifts because SRAI encodes it in the same place.
   function automatic logic [OPW-1:0] arith_op_f(
      input logic [2:0] f3,
      input logic       f7b5,
      input logic       is_r
   );
      logic [OPW-1:0] op;
      case (f3)
         3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
         3'b111:  op = ALU_AND;
         3'b110:  op = ALU_OR;
         3'b100:  op = ALU_XOR;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b001:  op = ALU_SLL;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   assign opcode_s = ir_q[6:0];
   assign funct3_s = ir_q[14:12];
   assign funct7_s = ir_q[31:25];

   // Only bit 0 of the ALU result carries information for this unit
   assign unused_s = ^alu_result[N-1:1];

   // Instruction class decode of the latched instruction
   always_comb begin
      is_r_s  = 1'b0;
      is_i_s  = 1'b0;
      is_lw_s = 1'b0;
      is_sw_s = 1'b0;
      is_br_s = 1'b0;
      case (opcode_s)
         OP_R:    is_r_s  = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
         OP_I:    is_i_s  = 1'b1;
         OP_LW:   is_lw_s = (funct3_s == 3'b010);
         OP_SW:   is_sw_s = (funct3_s == 3'b010);
         OP_BR:   is_br_s = (funct3_s == 3'b000) || (funct3_s == 3'b001);
         default: is_r_s  = 1'b0;
      endcase
      legal_s = is_r_s | is_i_s | is_lw_s | is_sw_s | is_br_s;
   end

   // ALU operation, operand source and immediate format for the class
   always_comb begin
      alu_op_s  = ALU_ADD;
      alusrc_s  = 1'b0;
      imm_sel_s = IMM_I;
      if (is_r_s) begin
         alu_op_s = arith_op_f(funct3_s, funct7_s[5], 1'b1);
      end else if (is_i_s) begin
         alu_op_s = arith_op_f(funct3_s, funct7_s[5], 1'b0);
         alusrc_s = 1'b1;
      end else if (is_lw_s) begin
         alusrc_s = 1'b1;
      end else if (is_sw_s) begin
         alusrc_s  = 1'b1;
         imm_sel_s = IMM_S;
      end else if (is_br_s) begin
         alu_op_s  = ALU_EQ;
         imm_sel_s = IMM_B;
      end else begin
         alu_op_s = ALU_ADD;
      end
   end

   // Next-state and instruction-register update
   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            if (instr_valid) begin
               ir_d    = instr;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (legal_s) begin
               state_d = S_EXECUTE;
            end else begin
               state_d = S_TRAP;
            end
         end
         S_EXECUTE: begin
            if (is_r_s || is_i_s) begin
               state_d = S_WB;
            end else if (is_lw_s || is_sw_s) begin
               state_d = S_MEM;
            end else begin
               // branch resolves and retires here
               state_d = S_FETCH;
            end
         end
         S_MEM: begin
            if (!mem_ready) begin
               state_d = S_MEM;
            end else if (is_lw_s) begin
               state_d = S_WB;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
         end
         S_TRAP: begin
            state_d = S_TRAP;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and instruction registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ir_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Moore output decode of state and instruction register
   always_comb begin
      instr_req       = 1'b0;
      ir_load         = 1'b0;
      rs1             = 5'd0;
      rs2             = 5'd0;
      rd              = 5'd0;
      imm_sel         = IMM_I;
      alu_instruction = ALU_ADD;
      alusrc          = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      reg_write       = 1'b0;
      wb_src          = 1'b0;
      pc_write        = 1'b0;
      pc_src          = 1'b0;
      illegal         = 1'b0;
      case (state_q)
         S_FETCH: begin
            instr_req = 1'b1;
            ir_load   = instr_valid;
         end
         S_DECODE: begin
            rs1     = ir_q[19:15];
            rs2     = ir_q[24:20];
            rd      = ir_q[11:7];
            imm_sel = imm_sel_s;
         end
         S_EXECUTE: begin
            rs1             = ir_q[19:15];
            rs2             = ir_q[24:20];
            rd              = ir_q[11:7];
            imm_sel         = imm_sel_s;
            alu_instruction = alu_op_s;
            alusrc          = alusrc_s;
            if (is_br_s) begin
               // BNE (funct3[0]=1) is taken when the equality compare fails
               pc_write = 1'b1;
               pc_src   = alu_result[0] ^ funct3_s[0];
            end else begin
               pc_write = 1'b0;
               pc_src   = 1'b0;
            end
         end
         S_MEM: begin
            rs1             = ir_q[19:15];
            rs2             = ir_q[24:20];
            rd              = ir_q[11:7];
            imm_sel         = imm_sel_s;
            alu_instruction = alu_op_s;
            alusrc          = alusrc_s;
            mem_read        = is_lw_s;
            mem_write       = is_sw_s;
            if (is_sw_s && mem_ready) begin
               // a store has no writeback, so it retires on completion
               pc_write = 1'b1;
            end else begin
               pc_write = 1'b0;
            end
         end
         S_WB: begin
            rs1       = ir_q[19:15];
            rs2       = ir_q[24:20];
            rd        = ir_q[11:7];
            reg_write = 1'b1;
            wb_src    = is_lw_s;
            pc_write  = 1'b1;
         end
         S_TRAP: begin
            illegal = 1'b1;
         end
         default: begin
            instr_req = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_alu_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_alu_control_fsm
//
// Scoreboard bench for alu_control_fsm. A driver issues directed and random
// instructions; for each one a reference model (working from instruction
// fields, mnemonics and the cycle budget of each instruction class) pushes an
// expected record. An independent monitor watches the DUT outputs on the
// falling edge, measures each instruction from its ir_load pulse to its
// pc_write pulse (or to illegal rising) and pops/compares the record.
// -----------------------------------------------------------------------------
module tb_alu_control_fsm;

   localparam int N   = 32;
   localparam int OPW = 4;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_EQ   = 4'd10;

   // packed view of all outputs: instr_req is bit 30, illegal is bit 0
   localparam logic [31:0] OUT_REQ_ONLY = 32'h4000_0000;
   localparam logic [31:0] OUT_ILL_ONLY = 32'h0000_0001;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [31:0]    instr = 32'd0;
   logic           instr_valid = 1'b0;
   logic           mem_ready;
   logic [N-1:0]   alu_result = '0;
   logic           instr_req, ir_load;
   logic [4:0]     rs1, rs2, rd;
   logic [1:0]     imm_sel;
   logic [OPW-1:0] alu_instruction;
   logic           alusrc, mem_read, mem_write, reg_write, wb_src;
   logic           pc_write, pc_src, illegal;

   int n_checks = 0;
   int n_fail   = 0;
   int cur_stall = 0;

   typedef struct {
      bit         trap;
      bit         chk_imm;
      logic       pc_src;
      int         lat;
      logic [3:0] alu;
      logic       alusrc;
      logic [1:0] imm;
      int         memr;
      int         memw;
      int         regw;
      logic       wbs;
   } exp_t;

   exp_t q[$];

   alu_control_fsm #(.N(N), .OPW(OPW)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
      .mem_ready(mem_ready), .alu_result(alu_result),
      .instr_req(instr_req), .ir_load(ir_load), .rs1(rs1), .rs2(rs2), .rd(rd),
      .imm_sel(imm_sel), .alu_instruction(alu_instruction), .alusrc(alusrc),
      .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
      .wb_src(wb_src), .pc_write(pc_write), .pc_src(pc_src), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] outs_f();
      return {1'b0, instr_req, ir_load, rs1, rs2, rd, imm_sel, alu_instruction,
              alusrc, mem_read, mem_write, reg_write, wb_src, pc_write, pc_src,
              illegal};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: what the control unit must do for one instruction
   function automatic exp_t model(input logic [31:0] w, input int stall, input logic equal);
      exp_t  e;
      string kind;
      string mn;
      logic [6:0] op = w[6:0];
      logic [2:0] f3 = w[14:12];
      logic [6:0] f7 = w[31:25];
      e.trap = 1'b0; e.chk_imm = 1'b1; e.pc_src = 1'b0; e.lat = 0;
      e.alu = ALU_ADD; e.alusrc = 1'b0; e.imm = 2'd0;
      e.memr = 0; e.memw = 0; e.regw = 0; e.wbs = 1'b0;
      kind = "bad";
      if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) kind = "R";
      else if (op == 7'h13) kind = "I";
      else if (op == 7'h03 && f3 == 3'd2) kind = "LW";
      else if (op == 7'h23 && f3 == 3'd2) kind = "SW";
      else if (op == 7'h63 && (f3 == 3'd0 || f3 == 3'd1)) kind = "BR";
      if (kind == "bad") begin
         e.trap = 1'b1;
         return e;
      end
      if (kind == "R" || kind == "I") begin
         case (f3)
            3'd0: mn = (kind == "R" && f7[5]) ? "sub" : "add";
            3'd1: mn = "sll";
            3'd2: mn = "slt";
            3'd3: mn = "sltu";
            3'd4: mn = "xor";
            3'd5: mn = f7[5] ? "sra" : "srl";
            3'd6: mn = "or";
            default: mn = "and";
         endcase
         if (mn == "add") e.alu = ALU_ADD;
         else if (mn == "sub") e.alu = ALU_SUB;
         else if (mn == "sll") e.alu = ALU_SLL;
         else if (mn == "slt") e.alu = ALU_SLT;
         else if (mn == "sltu") e.alu = ALU_SLTU;
         else if (mn == "xor") e.alu = ALU_XOR;
         else if (mn == "sra") e.alu = ALU_SRA;
         else if (mn == "srl") e.alu = ALU_SRL;
         else if (mn == "or") e.alu = ALU_OR;
         else e.alu = ALU_AND;
         e.alusrc = (kind == "I");
         e.chk_imm = (kind == "I");
         e.lat = 4;
         e.regw = 1;
      end else if (kind == "LW") begin
         e.alusrc = 1'b1; e.lat = 5 + stall; e.memr = stall + 1;
         e.regw = 1; e.wbs = 1'b1;
      end else if (kind == "SW") begin
         e.alusrc = 1'b1; e.imm = 2'd1; e.lat = 4 + stall; e.memw = stall + 1;
      end else begin
         e.alu = ALU_EQ; e.imm = 2'd2; e.lat = 3;
         e.pc_src = (f3 == 3'd0) ? equal : !equal;
      end
      return e;
   endfunction

   function automatic logic [31:0] gen_instr();
      logic [31:0] w = $urandom;
      int k = $urandom_range(0, 11);
      case (k)
         0, 1, 2: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00; end
         3, 4:    w[6:0] = 7'h13;
         5, 6:    begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
         7:       begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
         8, 9:    begin w[6:0] = 7'h63; w[14:12] = 3'($urandom_range(0, 1)); end
         10: begin
            case ($urandom_range(0, 3))
               0: w[6:0] = 7'h33;
               1: w[6:0] = 7'h03;
               2: w[6:0] = 7'h23;
               default: w[6:0] = 7'h63;
            endcase
         end
         default: w[6:0] = 7'($urandom);
      endcase
      return w;
   endfunction

   task automatic finish_now();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   endtask

   // Issue one instruction once the DUT is in FETCH; called at posedge+1
   task automatic issue(input logic [31:0] w, input int stall, input logic equal, output bit is_trap);
      exp_t e;
      int   waited = 0;
      int   gap;
      while (!instr_req) begin
         // noise outside FETCH must be ignored by the DUT
         instr_valid = 1'($urandom_range(0, 1));
         instr = $urandom;
         @(posedge clk); #1;
         waited++;
         if (waited > 60) begin
            n_checks++; n_fail++;
            $display("FAIL fetch_timeout: instr_req not seen after %0d cycles", waited);
            finish_now();
         end
      end
      instr_valid = 1'b0;
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge clk); #1; end
      cur_stall = stall;
      alu_result = {$urandom} ;
      alu_result[0] = equal;
      e = model(w, stall, equal);
      is_trap = e.trap;
      q.push_back(e);
      instr = w;
      instr_valid = 1'b1;
      @(posedge clk); #1;
      instr_valid = 1'b0;
   endtask

   task automatic do_reset(input bit allow_pending);
      if (!allow_pending) check("pending_at_reset", q.size(), 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs", outs_f(), 32'd0);
      q.delete();
      instr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check("idle_after_reset", outs_f(), 32'd0);
   endtask

   task automatic run_one(input logic [31:0] w, input int stall, input logic equal);
      bit t;
      issue(w, stall, equal, t);
      if (t) begin
         repeat (12) begin @(posedge clk); #1; end
         do_reset(1'b0);
      end
   endtask

   // Data memory responder: completes each access after cur_stall wait cycles
   initial begin
      int left = 0;
      mem_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && (mem_read || mem_write)) begin
            if (left == 0) mem_ready = 1'b1;
            else begin mem_ready = 1'b0; left--; end
         end else begin
            mem_ready = 1'b0;
            left = cur_stall;
         end
      end
   end

   // Monitor: measures each instruction and compares against the scoreboard
   initial begin
      int cyc = 0, start = 0, memr = 0, memw = 0, regw = 0;
      bit active = 1'b0, trap_flag = 1'b0;
      logic wbs = 1'b0;
      logic [3:0] cap_alu = 4'd0;
      logic cap_src = 1'b0;
      logic [1:0] cap_imm = 2'd0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            active = 1'b0;
            trap_flag = 1'b0;
            continue;
         end
         cyc++;
         if (trap_flag) check("trap_hold", outs_f(), OUT_ILL_ONLY);
         if (ir_load) begin
            if (active) check("overlapping_fetch", 1, 0);
            active = 1'b1; start = cyc;
            memr = 0; memw = 0; regw = 0; wbs = 1'b0;
         end
         if (active) begin
            if (mem_read) memr++;
            if (mem_write) memw++;
            if ((mem_read || mem_write) && cyc > start + 2)
               check("mem_alu_hold", {alu_instruction, alusrc}, {cap_alu, cap_src});
            if (reg_write) begin regw++; wbs = wb_src; end
            if (cyc == start + 2) begin
               cap_alu = alu_instruction; cap_src = alusrc; cap_imm = imm_sel;
               if (illegal) begin
                  if (q.size() == 0) check("scoreboard_empty", 0, 1);
                  else begin
                     e = q.pop_front();
                     check("trap", 1, {31'd0, e.trap});
                  end
                  active = 1'b0;
                  trap_flag = 1'b1;
               end
            end
            if (active && pc_write) begin
               if (q.size() == 0) check("scoreboard_empty", 0, 1);
               else begin
                  e = q.pop_front();
                  check("trap", 0, {31'd0, e.trap});
                  check("latency", cyc - start + 1, e.lat);
                  check("pc_src", pc_src, e.pc_src);
                  check("alu_op", cap_alu, e.alu);
                  check("alusrc", cap_src, e.alusrc);
                  if (e.chk_imm) check("imm_sel", cap_imm, e.imm);
                  check("mem_read_cycles", memr, e.memr);
                  check("mem_write_cycles", memw, e.memw);
                  check("reg_write_pulses", regw, e.regw);
                  if (e.regw != 0) check("wb_src", wbs, e.wbs);
               end
               active = 1'b0;
            end
         end else if (pc_write || reg_write || mem_read || mem_write) begin
            check("stray_pulse", {pc_write, reg_write, mem_read, mem_write}, 0);
         end
      end
   end

   // Stimulus
   initial begin
      bit t;
      int cnt;
      // reset release with no instruction offered
      repeat (3) @(posedge clk);
      #2; rst_n = 1'b1; #1;
      check("idle_state", outs_f(), 32'd0);
      repeat (3) begin
         @(posedge clk); #1;
         check("fetch_wait", outs_f(), OUT_REQ_ONLY);
      end
      // directed cases
      run_one(32'h4020_8033, 0, 1'b0);   // sub x0,x1,x2
      run_one(32'h0000_A103, 2, 1'b0);   // lw x2,0(x1) with two wait cycles
      run_one(32'h0020_8463, 0, 1'b1);   // beq taken
      run_one(32'h0020_8463, 0, 1'b0);   // beq not taken
      run_one(32'h0020_9463, 0, 1'b1);   // bne not taken
      run_one(32'h0020_9463, 0, 1'b0);   // bne taken
      run_one(32'h0020_A423, 0, 1'b0);   // sw zero wait
      run_one(32'h0000_006F, 0, 1'b0);   // jal -> trap, then reset
      // reset while a store is waiting on memory
      issue(32'h0020_A423, 6, 1'b0, t);
      cnt = 0;
      while (!mem_write && cnt < 20) begin @(posedge clk); #1; cnt++; end
      check("reached_mem", mem_write, 1);
      do_reset(1'b1);
      // random traffic
      for (int i = 0; i < 150; i++) begin
         run_one(gen_instr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      cnt = 0;
      while (q.size() != 0 && cnt < 50) begin @(posedge clk); #1; cnt++; end
      check("drain", q.size(), 0);
      finish_now();
   end

endmodule
